ps2_key_decoder: RTL and testbench

Upstream stage of the lab06 keyboard-driven controllers. It receives raw PS/2 device-to-host frames on the two keyboard lines and decodes scan-code set 2 make/break/extended sequences. It maintains a 512-bit key-down map and emits a one-cycle key_valid strobe with the 9-bit key index. Downstream FSMs consume key_down, last_change and key_valid directly.

---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_frame_rx.sv | 99 +++++++++
 rtl/ps2_key_decoder.sv | 135 +++++++++++++
 tb/tb_ps2_key_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code set 2 receiver and key decoder.
package ps2_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;
    localparam int FRAME_BITS = 11;
    localparam int KEY_IDX_W  = 9;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        RESOLVE
    } byte_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronizers, PS2_CLK glitch filter,
// bit assembly, inactivity timeout and start/parity/stop checking.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(FRAME_BITS);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          filt_level;
    logic [FW-1:0] filt_cnt;
    logic [BW-1:0] bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] to_cnt;
    logic          fall;
    logic          frame_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Level only changes once the new value has been seen FILTER_LEN cycles in a row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_level <= 1'b1;
            filt_cnt   <= '0;
        end else if (clk_sync[1] == filt_level) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_level <= clk_sync[1];
            filt_cnt   <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign fall = filt_level && !clk_sync[1] && (filt_cnt == FW'(FILTER_LEN - 1));

    // shreg holds {parity, D7..D0, start} once ten bits are in; the stop bit is live data.
    assign frame_ok = !shreg[0] && data_sync[1] && (^shreg[9:1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            to_cnt   <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                if (bit_cnt == BW'(FRAME_BITS - 1)) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        rx_byte  <= shreg[8:1];
                        rx_valid <= 1'b1;
                    end else begin
                        rx_err <= 1'b1;
                    end
                end else begin
                    shreg   <= {data_sync[1], shreg[9:1]};
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end else if (bit_cnt == '0) begin
                to_cnt <= '0;
            end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                rx_err  <= 1'b1;
                bit_cnt <= '0;
                to_cnt  <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Scan-code set 2 make/break/extended decoder maintaining a 512-entry key-down map.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 PS2_CLK,
    input  logic                 PS2_DATA,
    output logic [511:0]         key_down,
    output logic [KEY_IDX_W-1:0] last_change,
    output logic                 key_valid,
    output logic                 frame_err
);

    logic [7:0]           rx_byte;
    logic                 rx_valid;
    logic                 rx_err;
    byte_state_t          state, state_d;
    logic                 ext_q, ext_d;
    logic                 brk_q, brk_d;
    logic [7:0]           byte_q, byte_d;
    logic                 proto_err;
    logic                 resolve;
    logic [KEY_IDX_W-1:0] idx;
    logic                 new_val;
    logic                 changed;
    logic                 err_d;

    ps2_frame_rx #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (PS2_CLK),
        .ps2_data(PS2_DATA),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_err  (rx_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            byte_q <= '0;
        end else begin
            state  <= state_d;
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            byte_q <= byte_d;
        end
    end

    always_comb begin
        state_d   = state;
        ext_d     = ext_q;
        brk_d     = brk_q;
        byte_d    = byte_q;
        proto_err = 1'b0;
        case (state)
            IDLE: if (rx_valid) begin
                byte_d = rx_byte;
                if (rx_byte == SC_EXT) begin
                    ext_d   = 1'b1;
                    state_d = EXT;
                end else if (rx_byte == SC_BRK) begin
                    brk_d   = 1'b1;
                    state_d = BRK;
                end else begin
                    state_d = RESOLVE;
                end
            end
            EXT: if (rx_valid) begin
                byte_d = rx_byte;
                if (rx_byte == SC_BRK) begin
                    brk_d   = 1'b1;
                    state_d = BRK;
                end else if (rx_byte != SC_EXT) begin
                    state_d = RESOLVE;
                end
            end
            BRK: if (rx_valid) begin
                byte_d = rx_byte;
                if (rx_byte == SC_EXT || rx_byte == SC_BRK) begin
                    proto_err = 1'b1;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                    state_d   = IDLE;
                end else begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                ext_d   = 1'b0;
                brk_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A dropped byte abandons any pending prefix; RESOLVE already returns to IDLE.
        if (rx_err && state != RESOLVE) begin
            ext_d   = 1'b0;
            brk_d   = 1'b0;
            state_d = IDLE;
        end
    end

    assign resolve = (state == RESOLVE);
    assign idx     = {ext_q, byte_q};
    assign new_val = ~brk_q;
    assign changed = resolve && (key_down[idx] != new_val);
    assign err_d   = (rx_err || proto_err) && !resolve;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_down    <= '0;
            last_change <= '0;
            key_valid   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            key_valid <= changed;
            frame_err <= err_d;
            if (changed) begin
                key_down[idx] <= new_val;
                last_change   <= idx;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed table-driven bench for ps2_key_decoder: PS/2 frame driver, strobe monitor, final report.
module tb_ps2_key_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 2000;
    localparam int HALF       = 20;
    localparam int GAP        = 60;
    localparam int LATENCY    = 2 + FILTER_LEN + 2;

    logic         clk;
    logic         rst;
    logic         PS2_CLK;
    logic         PS2_DATA;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;
    logic         frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int kv_total = 0;
    int fe_total = 0;
    int both_total = 0;
    int kv_cyc = 0;
    int stop_cyc = 0;

    ps2_key_decoder #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PS2_CLK    (PS2_CLK),
        .PS2_DATA   (PS2_DATA),
        .key_down   (key_down),
        .last_change(last_change),
        .key_valid  (key_valid),
        .frame_err  (frame_err)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: counts high cycles, so a stretched pulse shows up as an extra count
    always @(negedge clk) begin
        if (key_valid) begin
            kv_total <= kv_total + 1;
            kv_cyc   <= cyc;
        end
        if (frame_err) fe_total <= fe_total + 1;
        if (key_valid && frame_err) both_total <= both_total + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit is_stop);
        @(negedge clk);
        PS2_DATA = b;
        repeat (HALF) @(negedge clk);
        PS2_CLK = 1'b0;
        if (is_stop) stop_cyc = cyc;
        repeat (HALF) @(negedge clk);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
        logic [10:0] f;
        logic        p;
        p = ~(^b) ^ bad;
        f = {1'b1, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], i == 10);
        @(negedge clk);
        PS2_DATA = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        send_frame(b, bad, 11);
        repeat (GAP) @(negedge clk);
    endtask

    typedef struct {
        logic [23:0] bytes;
        int          n;
        bit          bad;
        bit          lat;
        logic [8:0]  ia;
        logic        va;
        logic [8:0]  ib;
        logic        vb;
        int          kv;
        int          fe;
        logic [8:0]  last;
        int          pop;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int          kv0;
        int          fe0;
        logic [23:0] bv;
        logic [7:0]  b;

        tbl[0]  = '{24'h690000, 1, 1'b0, 1'b1, 9'h069, 1'b1, 9'h169, 1'b0, 1, 0, 9'h069, 1};
        tbl[1]  = '{24'hF00000, 1, 1'b0, 1'b0, 9'h069, 1'b1, 9'h0F0, 1'b0, 0, 0, 9'h069, 1};
        tbl[2]  = '{24'h690000, 1, 1'b0, 1'b1, 9'h069, 1'b0, 9'h169, 1'b0, 1, 0, 9'h069, 0};
        tbl[3]  = '{24'hE07500, 2, 1'b0, 1'b1, 9'h175, 1'b1, 9'h075, 1'b0, 1, 0, 9'h175, 1};
        tbl[4]  = '{24'hE0F075, 3, 1'b0, 1'b1, 9'h175, 1'b0, 9'h075, 1'b0, 1, 0, 9'h175, 0};
        tbl[5]  = '{24'h727272, 3, 1'b0, 1'b0, 9'h072, 1'b1, 9'h172, 1'b0, 1, 0, 9'h072, 1};
        tbl[6]  = '{24'h690000, 1, 1'b1, 1'b0, 9'h069, 1'b0, 9'h072, 1'b1, 0, 1, 9'h072, 1};
        tbl[7]  = '{24'h690000, 1, 1'b0, 1'b1, 9'h069, 1'b1, 9'h072, 1'b1, 1, 0, 9'h069, 2};
        tbl[8]  = '{24'hF0E000, 2, 1'b0, 1'b0, 9'h069, 1'b1, 9'h0E0, 1'b0, 0, 1, 9'h069, 2};
        tbl[9]  = '{24'hF07200, 2, 1'b0, 1'b1, 9'h072, 1'b0, 9'h069, 1'b1, 1, 0, 9'h072, 1};
        tbl[10] = '{24'hE0F069, 3, 1'b0, 1'b0, 9'h169, 1'b0, 9'h069, 1'b1, 0, 0, 9'h072, 1};
        tbl[11] = '{24'hF06900, 2, 1'b0, 1'b1, 9'h069, 1'b0, 9'h072, 1'b0, 1, 0, 9'h069, 0};

        // Reset block
        rst      = 1'b0;
        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_key_down_pop", $countones(key_down), 0);
        check("reset_last_change", 32'(last_change), 0);
        check("reset_key_valid", 32'(key_valid), 0);
        check("reset_frame_err", 32'(frame_err), 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            kv0 = kv_total;
            fe0 = fe_total;
            bv  = tbl[i].bytes;
            for (int k = 0; k < tbl[i].n; k++) begin
                b = bv[23-8*k -: 8];
                send_byte(b, tbl[i].bad);
            end
            check($sformatf("row%0d_key_valid_count", i), kv_total - kv0, tbl[i].kv);
            check($sformatf("row%0d_frame_err_count", i), fe_total - fe0, tbl[i].fe);
            check($sformatf("row%0d_last_change", i), 32'(last_change), 32'(tbl[i].last));
            check($sformatf("row%0d_key_down_a", i), 32'(key_down[tbl[i].ia]), 32'(tbl[i].va));
            check($sformatf("row%0d_key_down_b", i), 32'(key_down[tbl[i].ib]), 32'(tbl[i].vb));
            check($sformatf("row%0d_key_down_pop", i), $countones(key_down), tbl[i].pop);
            if (tbl[i].lat)
                check($sformatf("row%0d_latency", i), kv_cyc - stop_cyc, LATENCY);
        end

        // Timeout after a 5-bit partial frame
        kv0 = kv_total;
        fe0 = fe_total;
        send_frame(8'h69, 1'b0, 5);
        repeat (TIMEOUT + 10) @(negedge clk);
        check("timeout_frame_err_count", fe_total - fe0, 1);
        check("timeout_key_valid_count", kv_total - kv0, 0);

        // Receiver recovers, then reset mid-frame with 0x69 held
        kv0 = kv_total;
        send_byte(8'h69, 1'b0);
        check("post_timeout_key_valid_count", kv_total - kv0, 1);
        check("post_timeout_key_down_069", 32'(key_down[9'h069]), 1);
        send_frame(8'h72, 1'b0, 5);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_key_down_pop", $countones(key_down), 0);
        check("midreset_last_change", 32'(last_change), 0);
        check("midreset_key_valid", 32'(key_valid), 0);
        check("midreset_frame_err", 32'(frame_err), 0);
        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (GAP) @(negedge clk);
        kv0 = kv_total;
        fe0 = fe_total;
        check("release_no_strobe_fe", fe_total - fe0, 0);
        send_byte(8'h72, 1'b0);
        check("release_key_valid_count", kv_total - kv0, 1);
        check("release_frame_err_count", fe_total - fe0, 0);
        check("release_last_change", 32'(last_change), 32'h072);
        check("release_key_down_072", 32'(key_down[9'h072]), 1);
        check("release_key_down_pop", $countones(key_down), 1);
        check("release_latency", kv_cyc - stop_cyc, LATENCY);

        check("strobes_never_together", both_total, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
